// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: glyph table, blank codes and
// counter-width helper.
package seg_scan_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0-F
   localparam logic [6:0] HEX7 [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = HEX7[nibble];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with ghost guard, frame-aligned
// shadow registers, leading-zero suppression and blink mode.
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int SCAN_DIV  = 50_000,
   parameter int GUARD     = 16,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] data,
   input  logic [3:0]  dp,
   input  logic        mode,
   input  logic        lz_en,
   output logic [7:0]  seg,
   output logic [3:0]  an,
   output logic        digit_tick
);

   localparam int SW = cnt_width(SCAN_DIV);
   localparam int BW = cnt_width(BLINK_DIV);

   localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] GUARD_END  = SW'(GUARD);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0] slot_cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          phase;
   logic [15:0]   data_s;
   logic [3:0]    dp_s;

   logic          slot_wrap;
   logic          frame_wrap;
   logic [3:0]    nibble;
   logic [6:0]    glyph;
   logic          upper_zero;
   logic          dark;

   assign slot_wrap  = (slot_cnt == SLOT_LAST);
   assign frame_wrap = slot_wrap && (idx == 2'd3);
   assign digit_tick = slot_wrap;
   assign nibble     = data_s[{idx, 2'b00} +: 4];

   seg_hex_decode u_decode (
      .nibble (nibble),
      .glyph  (glyph)
   );

   // A digit is suppressed when it and every digit to its left are zero
   always_comb begin
      upper_zero = 1'b0;
      case (idx)
         2'd1:    upper_zero = (data_s[15:4]  == 12'h000);
         2'd2:    upper_zero = (data_s[15:8]  == 8'h00);
         2'd3:    upper_zero = (data_s[15:12] == 4'h0);
         default: upper_zero = 1'b0;
      endcase
   end

   assign dark = (slot_cnt < GUARD_END) || (!mode && phase) || (lz_en && upper_zero);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_cnt <= '0;
         idx      <= 2'd0;
      end else if (slot_wrap) begin
         slot_cnt <= '0;
         idx      <= idx + 2'd1;
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   // Inputs are captured once per frame so a frame never shows mixed data
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_s <= 16'h0000;
         dp_s   <= 4'h0;
      end else if (frame_wrap) begin
         data_s <= data;
         dp_s   <= dp;
      end
   end

   // Steady mode parks the blink timer so a switch to blink starts lit
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (mode) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
      end else if (dark) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= {~dp_s[idx], glyph};
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: a cycle-count reference model plus
// hand-computed checkpoints, followed by randomized stimulus.
module tb_seg_scan;

   localparam int SD = 8;
   localparam int G  = 2;
   localparam int BD = 64;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] data = 16'h0000;
   logic [3:0]  dp = 4'h0;
   logic        mode = 1'b1;
   logic        lz_en = 1'b0;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        digit_tick;

   int checks = 0;
   int errors = 0;

   logic [7:0] glyph_tab [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   seg_scan #(.SCAN_DIV(SD), .GUARD(G), .BLINK_DIV(BD)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .data       (data),
      .dp         (dp),
      .mode       (mode),
      .lz_en      (lz_en),
      .seg        (seg),
      .an         (an),
      .digit_tick (digit_tick)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: cycles since reset determine slot and digit directly
   longint     n;
   int         bc;
   bit         ph;
   logic [15:0] shd;
   logic [3:0]  shdp;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_an;
   logic        exp_tick;

   always @(posedge clk) begin
      int cnt, idx, upper;
      if (!rstn) begin
         n = 0; bc = 0; ph = 0; shd = 16'h0; shdp = 4'h0;
         exp_seg = 8'hFF; exp_an = 4'hF;
      end else begin
         cnt   = int'(n % SD);
         idx   = int'((n / SD) % 4);
         upper = int'(shd) >> (4 * idx);
         if (cnt < G || (!mode && ph) || (lz_en && idx != 0 && upper == 0)) begin
            exp_seg = 8'hFF; exp_an = 4'hF;
         end else begin
            exp_an  = ~(4'b0001 << idx);
            exp_seg = glyph_tab[upper % 16];
            if (shdp[idx]) exp_seg[7] = 1'b0;
         end
         if ((n + 1) % (4 * SD) == 0) begin
            shd = data; shdp = dp;
         end
         n++;
         if (mode) begin
            bc = 0; ph = 0;
         end else if (bc == BD - 1) begin
            bc = 0; ph = ~ph;
         end else begin
            bc++;
         end
      end
      exp_tick = rstn && (n % SD == SD - 1);
      #1;
      checkOutput("model_an", {12'h0, an}, {12'h0, exp_an});
      checkOutput("model_seg", {8'h0, seg}, {8'h0, exp_seg});
      checkOutput("model_tick", {15'h0, digit_tick}, {15'h0, exp_tick});
   end

   task automatic applyStimulus(input int edges);
      repeat (edges) @(posedge clk);
      #2;
   endtask

   initial begin
      data = 16'h1234; dp = 4'h0; mode = 1'b1; lz_en = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_an", {12'h0, an}, 16'h000F);
      checkOutput("reset_seg", {8'h0, seg}, 16'h00FF);
      rstn = 1'b1;

      applyStimulus(17);
      checkOutput("guard_f1_an", {12'h0, an}, 16'h000F);
      applyStimulus(3);
      checkOutput("f1_d2_an", {12'h0, an}, 16'h000B);
      checkOutput("f1_d2_seg", {8'h0, seg}, 16'h00C0);
      applyStimulus(13);
      checkOutput("guard_f2_seg", {8'h0, seg}, 16'h00FF);
      applyStimulus(2);
      checkOutput("f2_d0_an", {12'h0, an}, 16'h000E);
      checkOutput("f2_d0_seg", {8'h0, seg}, 16'h0099);
      applyStimulus(8);
      checkOutput("f2_d1_seg", {8'h0, seg}, 16'h00B0);
      applyStimulus(8);
      checkOutput("f2_d2_seg", {8'h0, seg}, 16'h00A4);
      applyStimulus(8);
      checkOutput("f2_d3_an", {12'h0, an}, 16'h0007);
      checkOutput("f2_d3_seg", {8'h0, seg}, 16'h00F9);
      applyStimulus(4);
      checkOutput("tick_lit", {15'h0, digit_tick}, 16'h0001);

      applyStimulus(7);
      @(negedge clk);
      data = 16'hABCD;
      applyStimulus(21);
      checkOutput("midframe_hold", {8'h0, seg}, 16'h00F9);
      applyStimulus(8);
      checkOutput("newframe_d0", {8'h0, seg}, 16'h00A1);
      applyStimulus(17);
      checkOutput("pre_reset_d2", {8'h0, seg}, 16'h0083);

      @(negedge clk);
      rstn = 1'b0;
      #1;
      checkOutput("async_an", {12'h0, an}, 16'h000F);
      checkOutput("async_seg", {8'h0, seg}, 16'h00FF);
      data = 16'h0050; lz_en = 1'b1;
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(2);
      checkOutput("restart_guard", {12'h0, an}, 16'h000F);
      applyStimulus(1);
      checkOutput("restart_d0_an", {12'h0, an}, 16'h000E);
      checkOutput("restart_d0_seg", {8'h0, seg}, 16'h00C0);
      applyStimulus(32);
      checkOutput("lz_d0", {8'h0, seg}, 16'h00C0);
      applyStimulus(8);
      checkOutput("lz_d1_an", {12'h0, an}, 16'h000D);
      checkOutput("lz_d1_seg", {8'h0, seg}, 16'h0092);
      applyStimulus(8);
      checkOutput("lz_d2_dark", {12'h0, an}, 16'h000F);
      applyStimulus(8);
      checkOutput("lz_d3_dark", {8'h0, seg}, 16'h00FF);
      @(negedge clk);
      data = 16'h0000;
      applyStimulus(8);
      checkOutput("zero_d0", {8'h0, seg}, 16'h00C0);
      applyStimulus(8);
      checkOutput("zero_d1_dark", {12'h0, an}, 16'h000F);

      @(negedge clk);
      mode = 1'b0; lz_en = 1'b0;
      applyStimulus(64);
      checkOutput("blink_last_lit", {12'h0, an}, 16'h000D);
      applyStimulus(1);
      checkOutput("blink_dark", {12'h0, an}, 16'h000F);
      @(negedge clk);
      mode = 1'b1;
      applyStimulus(1);
      checkOutput("steady_again", {12'h0, an}, 16'h000D);
      checkOutput("steady_seg", {8'h0, seg}, 16'h00C0);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(15) == 0) data = 16'($urandom);
         if ($urandom_range(15) == 0) dp = 4'($urandom);
         if ($urandom_range(63) == 0) lz_en = ~lz_en;
         if ($urandom_range(299) == 0) mode = ~mode;
         rstn = ($urandom_range(1499) != 0);
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
